seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed-display scan controller for N-digit 7-segment displays.

---
 rtl/seg_scan_if.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// Interface : seg_scan_if
// Purpose   : Control inputs and digit-scan outputs of seg_scan_ctrl.
//             master = system side driving the controls, slave = scan controller.
// Options   : SEG_SCAN_DIM_EN adds the per-digit duty (dimming) control.
// Revision  : 1.0 - initial release
// ============================================================================
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 16
);
  localparam int SEL_W = $clog2(NUM_DIGITS);

  logic                  enable;
  logic [DIV_WIDTH-1:0]  div_value;
  logic [NUM_DIGITS-1:0] digit_mask;
`ifdef SEG_SCAN_DIM_EN
  logic [DIV_WIDTH-1:0]  duty;
`endif
  logic [SEL_W-1:0]      SEL;
  logic [NUM_DIGITS-1:0] CAT;
  logic                  frame_tick;

`ifdef SEG_SCAN_DIM_EN
  modport master (output enable, div_value, digit_mask, duty,
                  input  SEL, CAT, frame_tick);
  modport slave  (input  enable, div_value, digit_mask, duty,
                  output SEL, CAT, frame_tick);
`else
  modport master (output enable, div_value, digit_mask,
                  input  SEL, CAT, frame_tick);
  modport slave  (input  enable, div_value, digit_mask,
                  output SEL, CAT, frame_tick);
`endif
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Multiplexed 7-segment scan controller. Steps through the enabled
//            digits, holding each for div_value+1 clocks, with an all-off
//            blanking gap of BLANK_CYCLES clocks between digits.
// Options  : SEG_SCAN_DIM_EN adds a duty input that shortens the lit part of
//            each digit's dwell (brightness control).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_WIDTH      = 16,
  parameter int BLANK_CYCLES   = 2,
  parameter bit CAT_ACTIVE_LOW = 1'b0
) (
  input wire        clock,
  input wire        reset,
  seg_scan_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_DIGITS);

  // Inactive CAT level: every bit off, inverted for active-low drivers
  localparam logic [NUM_DIGITS-1:0] c_cat_off = CAT_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_e;

  state_e                r_state;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_DIGITS-1:0] r_cat;
  logic                  r_ft;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [DIV_WIDTH-1:0]  r_dwell;

  // First set mask bit strictly after cur, wrapping; cur itself is checked last
  // so a single-digit mask selects the same digit again.
  function automatic logic [SEL_W-1:0] f_next_sel(input logic [NUM_DIGITS-1:0] mask,
                                                  input logic [SEL_W-1:0]      cur);
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = cur;
    found = 1'b0;
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      int idx;
      idx = (int'(cur) + i) % NUM_DIGITS;
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
    return pick;
  endfunction

  // Digit i drives CAT bit NUM_DIGITS-1-i; lit=0 gives the inactive pattern
  function automatic logic [NUM_DIGITS-1:0] f_cat(input logic [SEL_W-1:0] sel,
                                                  input logic             lit);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = '0;
    if (lit) onehot[NUM_DIGITS-1-int'(sel)] = 1'b1;
    return onehot ^ c_cat_off;
  endfunction

  logic             w_mask_any;
  logic [SEL_W-1:0] w_first_sel;
  logic [SEL_W-1:0] w_adv_sel;
  logic             w_dwell_done;
  logic             w_blank_done;
  logic             w_enter_show;
  logic [SEL_W-1:0] w_entry_sel;
  logic             w_entry_ft;
  logic             w_lit_entry;
  logic             w_lit_next;

  assign w_mask_any   = |bus.digit_mask;
  // Searching "after" the top digit yields the lowest set bit
  assign w_first_sel  = f_next_sel(bus.digit_mask, SEL_W'(NUM_DIGITS - 1));
  assign w_adv_sel    = f_next_sel(bus.digit_mask, r_sel);
  assign w_dwell_done = (r_cnt == r_dwell);
  // With no gap configured, BLANK is only used as the wait state for an empty mask
  assign w_blank_done = (BLANK_CYCLES == 0) || (r_cnt == DIV_WIDTH'(BLANK_CYCLES - 1));

  // A new digit starts from IDLE, at the end of a gap-less dwell, or once the gap
  // is over; with an empty mask the FSM parks in BLANK and retries every clock.
  assign w_enter_show = w_mask_any &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_SHOW  && w_dwell_done && BLANK_CYCLES == 0) ||
                         (r_state == S_BLANK && w_blank_done));
  assign w_entry_sel  = (r_state == S_IDLE) ? w_first_sel : w_adv_sel;
  // Moving to the same or a lower index means the scan wrapped: new frame
  assign w_entry_ft   = (r_state == S_IDLE) ? 1'b1 : (w_adv_sel <= r_sel);

`ifdef SEG_SCAN_DIM_EN
  logic [DIV_WIDTH-1:0] r_duty;
  assign w_lit_entry = (bus.duty != '0);
  assign w_lit_next  = ((r_cnt + DIV_WIDTH'(1)) < r_duty);
`else
  assign w_lit_entry = 1'b1;
  assign w_lit_next  = 1'b1;
`endif

  // Scan sequencer: state, digit index, dwell/gap counter and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cat   <= c_cat_off;
      r_ft    <= 1'b0;
      r_cnt   <= '0;
      r_dwell <= '0;
`ifdef SEG_SCAN_DIM_EN
      r_duty  <= '0;
`endif
    end else if (!bus.enable) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cat   <= c_cat_off;
      r_ft    <= 1'b0;
      r_cnt   <= '0;
    end else if (w_enter_show) begin
      r_state <= S_SHOW;
      r_sel   <= w_entry_sel;
      r_cat   <= f_cat(w_entry_sel, w_lit_entry);
      r_ft    <= w_entry_ft;
      r_cnt   <= '0;
      r_dwell <= bus.div_value;
`ifdef SEG_SCAN_DIM_EN
      r_duty  <= bus.duty;
`endif
    end else begin
      r_ft <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cat <= c_cat_off;
        end
        S_SHOW: begin
          if (w_dwell_done) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            r_cat   <= c_cat_off;
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
            r_cat <= f_cat(r_sel, w_lit_next);
          end
        end
        S_BLANK: begin
          // Counter holds once the gap is over so an empty mask keeps retrying
          if (!w_blank_done) r_cnt <= r_cnt + DIV_WIDTH'(1);
          r_cat <= c_cat_off;
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= '0;
          r_cat   <= c_cat_off;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.SEL        = r_sel;
  assign bus.CAT        = r_cat;
  assign bus.frame_tick = r_ft;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Directed scoreboard bench for seg_scan_ctrl: a 4-digit active-high
//            instance with a 2-clock gap and an 8-digit active-low gap-less one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  // Free-running 100 MHz clock
  always #5 clock = ~clock;

  seg_scan_if #(.NUM_DIGITS(4), .DIV_WIDTH(16)) bus_a ();
  seg_scan_if #(.NUM_DIGITS(8), .DIV_WIDTH(16)) bus_b ();

  seg_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(16), .BLANK_CYCLES(2), .CAT_ACTIVE_LOW(1'b0))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  seg_scan_ctrl #(.NUM_DIGITS(8), .DIV_WIDTH(16), .BLANK_CYCLES(0), .CAT_ACTIVE_LOW(1'b1))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  // Expected value layout: {sel[3:0], cat[7:0], frame_tick}
  typedef struct packed {
    logic        dut_b;
    logic [12:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [12:0] obs(input logic which);
    if (which) return {1'b0, bus_b.SEL, bus_b.CAT, bus_b.frame_tick};
    return {2'b00, bus_a.SEL, 4'b0000, bus_a.CAT, bus_a.frame_tick};
  endfunction

  function automatic logic [3:0] cat_a(input int d);
    logic [3:0] t;
    t = 4'b1000;
    return t >> d;
  endfunction

  function automatic logic [7:0] cat_b(input int d);
    logic [7:0] t;
    t = 8'h80;
    return ~(t >> d);
  endfunction

  task automatic push_a(input int sel, input logic [3:0] cat, input logic ft);
    exp_t e;
    e.dut_b = 1'b0;
    e.val   = {sel[3:0], 4'b0000, cat, ft};
    q.push_back(e);
  endtask

  task automatic push_b(input int sel, input logic [7:0] cat, input logic ft);
    exp_t e;
    e.dut_b = 1'b1;
    e.val   = {sel[3:0], cat, ft};
    q.push_back(e);
  endtask

  task automatic push_show(input int d, input int n, input logic ft_first);
    for (int i = 0; i < n; i++) push_a(d, cat_a(d), ft_first && (i == 0));
  endtask

  task automatic push_off(input int d, input int n);
    for (int i = 0; i < n; i++) push_a(d, 4'b0000, 1'b0);
  endtask

  // Whole frames for dut_a: each enabled digit lit div+1 clocks, then a 2-clock gap
  task automatic push_frames_a(input logic [3:0] mask, input int div, input int nf);
    logic first;
    for (int f = 0; f < nf; f++) begin
      first = 1'b1;
      for (int d = 0; d < 4; d++) begin
        if (mask[d]) begin
          push_show(d, div + 1, first);
          push_off(d, 2);
          first = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t        e;
    logic [12:0] o;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed output with empty scoreboard, required an expected entry", tag);
    end else begin
      e = q.pop_front();
      o = obs(e.dut_b);
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed sel/cat/tick %h, required %h (dut_b=%0b)", tag, o, e.val, e.dut_b);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      compare_front(tag);
    end
  endtask

  // Directed sequence; inputs change only right after a falling-edge check
  initial begin
    reset               = 1'b0;
    bus_a.enable        = 1'b0;
    bus_a.div_value     = 16'd3;
    bus_a.digit_mask    = 4'hF;
    bus_b.enable        = 1'b0;
    bus_b.div_value     = 16'd0;
    bus_b.digit_mask    = 8'hFF;
`ifdef SEG_SCAN_DIM_EN
    bus_a.duty          = 16'hFFFF;
    bus_b.duty          = 16'hFFFF;
`endif

    repeat (2) @(negedge clock);
    push_a(0, 4'b0000, 1'b0);
    push_b(0, 8'hFF, 1'b0);
    compare_front("reset_a");
    compare_front("reset_b");
    reset = 1'b1;
    push_a(0, 4'b0000, 1'b0);
    run(1, "idle_disabled");

    // All four digits, dwell 4, gap 2: frame every 24 clocks
    bus_a.enable = 1'b1;
    push_frames_a(4'hF, 3, 2);
    run(48, "scan_mask_1111");

    // Digits 1 and 3 only: frame every 12 clocks
    bus_a.enable = 1'b0;
    push_a(0, 4'b0000, 1'b0);
    run(1, "disable_to_idle");
    bus_a.digit_mask = 4'b1010;
    bus_a.enable     = 1'b1;
    push_frames_a(4'b1010, 3, 2);
    run(24, "scan_mask_1010");

    // Minimum dwell of one clock
    bus_a.enable = 1'b0;
    push_a(0, 4'b0000, 1'b0);
    run(1, "disable_to_idle");
    bus_a.digit_mask = 4'hF;
    bus_a.div_value  = 16'd0;
    bus_a.enable     = 1'b1;
    push_frames_a(4'hF, 0, 2);
    run(24, "scan_div_0");

    // Mask emptied mid-dwell of digit 1; dwell also changed and must not apply yet
    bus_a.enable = 1'b0;
    push_a(0, 4'b0000, 1'b0);
    run(1, "disable_to_idle");
    bus_a.div_value = 16'd3;
    bus_a.enable    = 1'b1;
    push_show(0, 4, 1'b1);
    push_off(0, 2);
    push_show(1, 1, 1'b0);
    run(7, "reach_digit1");
    bus_a.digit_mask = 4'b0000;
    bus_a.div_value  = 16'd1;
    push_show(1, 3, 1'b0);
    push_off(1, 2);
    push_off(1, 5);
    run(10, "empty_mask_hold");
    bus_a.digit_mask = 4'b0001;
    push_show(0, 2, 1'b1);
    push_off(0, 2);
    push_show(0, 2, 1'b1);
    push_off(0, 2);
    run(8, "single_digit_resume");

    // Asynchronous reset while digit 2 is lit
    bus_a.enable = 1'b0;
    push_a(0, 4'b0000, 1'b0);
    run(1, "disable_to_idle");
    bus_a.digit_mask = 4'hF;
    bus_a.div_value  = 16'd3;
    bus_a.enable     = 1'b1;
    push_show(0, 4, 1'b1);
    push_off(0, 2);
    push_show(1, 4, 1'b0);
    push_off(1, 2);
    push_show(2, 1, 1'b0);
    run(13, "reach_digit2");
    #2;
    reset = 1'b0;
    #1;
    push_a(0, 4'b0000, 1'b0);
    compare_front("async_reset");
    @(negedge clock);
    reset = 1'b1;
    push_show(0, 4, 1'b1);
    run(4, "restart_after_reset");

    // Active-low, 8 digits, no gap, one-clock dwell
    bus_b.enable = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 8; d++)
        push_b(d, cat_b(d), d == 0);
    run(16, "low_active_scan");
    bus_b.digit_mask = 8'h00;
    for (int i = 0; i < 3; i++) push_b(7, 8'hFF, 1'b0);
    run(3, "low_active_empty_mask");
    bus_b.digit_mask = 8'b0010_0100;
    push_b(2, cat_b(2), 1'b1);
    push_b(5, cat_b(5), 1'b0);
    push_b(2, cat_b(2), 1'b1);
    run(3, "low_active_resume");
    bus_b.enable = 1'b0;
    push_b(0, 8'hFF, 1'b0);
    run(1, "low_active_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
